// File: rtl/act_lut_if.sv
// rtl/act_lut_if.sv - handshake and ROM bus bundle for the activation lookup stage
//
// Purpose: groups the request, accumulator, ROM and result signals of act_lut.
// Ports (members):
//   start     request pulse from the layer sequencer
//   acc       signed MAC accumulator, sampled with start
//   rom_addr  address to the external synchronous sigmoid ROM
//   rom_data  ROM read data, one clock after rom_addr
//   act       registered activation result
//   done      one-cycle completion pulse
//   busy      stage is processing a request
// Modports: master = sequencer/ROM side, slave = act_lut.

interface act_lut_if #(
  parameter int ACC_W = 26,
  parameter int AW    = 11,
  parameter int DW    = 8
);
  logic                    start;
  logic signed [ACC_W-1:0] acc;
  logic [AW-1:0]           rom_addr;
  logic [DW-1:0]           rom_data;
  logic [DW-1:0]           act;
  logic                    done;
  logic                    busy;

  modport master (
    output start, acc, rom_data,
    input  rom_addr, act, done, busy
  );

  modport slave (
    input  start, acc, rom_data,
    output rom_addr, act, done, busy
  );
endinterface

// File: rtl/act_lut.sv
// rtl/act_lut.sv - saturating accumulator-to-activation lookup stage (sigmoid ROM or ReLU)
//
// Purpose: on start, captures the MAC accumulator, saturates it to an AW-bit
// signed fixed-point value, addresses the external synchronous ROM with the
// offset-binary form of that value and registers the returned activation,
// pulsing done for one cycle.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    act_lut_if.slave: start/acc in, rom_addr out, rom_data in,
//          act/done/busy out
// Optional feature macro: ACT_RELU_EN - bypasses the ROM and produces a ReLU
// of the saturated value instead (same state sequence and latency).

module act_lut #(
  parameter int ACC_W    = 26,
  parameter int AW       = 11,
  parameter int DW       = 8,
  parameter int FRAC_LSB = 7
) (
  input  logic     clk,
  input  logic     rst_n,
  act_lut_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SAT  = 2'd1,
    READ = 2'd2,
    CAPT = 2'd3
  } state_t;

  localparam int QW = ACC_W - FRAC_LSB;  // bits kept from the accumulator

  state_t        state;
  // Bits below FRAC_LSB never reach the result, so they are not stored.
  logic [QW-1:0] acc_q;
  logic [AW-1:0] sat;

  logic          sign;
  logic [QW-AW-1:0] hi;  // bits between the sign and the kept field

  assign sign = acc_q[QW-1];
  assign hi   = acc_q[QW-2:AW-1];

  // The kept field fits only if every hi bit equals the sign; otherwise
  // clamp to the extreme of the matching sign.
  always_comb begin
    sat = acc_q[AW-1:0];
    if (!sign && (|hi)) begin
      sat = {1'b0, {(AW-1){1'b1}}};
    end else if (sign && !(&hi)) begin
      sat = {1'b1, {(AW-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc_q        <= '0;
      bus.rom_addr <= '0;
      bus.act      <= '0;
      bus.done     <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc_q    <= bus.acc[ACC_W-1:FRAC_LSB];
            bus.busy <= 1'b1;
            state    <= SAT;
          end
        end
        SAT: begin
          // Inverting the MSB maps signed sat onto 0..2^AW-1 (offset binary).
          bus.rom_addr <= {~sat[AW-1], sat[AW-2:0]};
          state        <= READ;
        end
        READ: begin
          // rom_addr held; the ROM samples it at the end of this cycle.
          state <= CAPT;
        end
        CAPT: begin
`ifdef ACT_RELU_EN
          bus.act <= sat[AW-1] ? '0 : sat[AW-2 -: DW];
`else
          bus.act <= bus.rom_data;
`endif
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_act_lut.sv
// tb/tb_act_lut.sv - directed self-checking bench for act_lut

module tb_act_lut;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  act_lut_if #(.ACC_W(26), .AW(11), .DW(8)) bus ();

  act_lut #(.ACC_W(26), .AW(11), .DW(8), .FRAC_LSB(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: 1-cycle synchronous read, data = addr[10:3]
  always @(posedge clk) bus.rom_data <= bus.rom_addr[10:3];

`ifdef ACT_RELU_EN
  localparam logic [7:0] ACT_ZERO = 8'h00;
  localparam logic [7:0] ACT_372  = 8'h5D;
  localparam logic [7:0] ACT_OVF  = 8'hFF;
  localparam logic [7:0] ACT_UNF  = 8'h00;
  localparam logic [7:0] ACT_NEG  = 8'h00;
`else
  localparam logic [7:0] ACT_ZERO = 8'h80;
  localparam logic [7:0] ACT_372  = 8'hAE;
  localparam logic [7:0] ACT_OVF  = 8'hFF;
  localparam logic [7:0] ACT_UNF  = 8'h00;
  localparam logic [7:0] ACT_NEG  = 8'h36;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pulse start for one edge, then follow the op to its done pulse.
  task automatic do_op(input string tag, input logic signed [25:0] a,
                       input logic [10:0] exp_addr, input logic [7:0] exp_act);
    int n;
    @(negedge clk);
    bus.acc   = a;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.acc   = 26'h2AA_AAAA;  // acc is free to change after the start edge
    check({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (bus.done !== 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) check({tag, " rom_addr_after_e1"}, 32'(bus.rom_addr), 32'(exp_addr));
    end
    check({tag, " done_latency"}, n, 32'd3);
    check({tag, " rom_addr"}, 32'(bus.rom_addr), 32'(exp_addr));
    check({tag, " act"}, 32'(bus.act), 32'(exp_act));
    check({tag, " busy_with_done"}, 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
    check({tag, " act_held"}, 32'(bus.act), 32'(exp_act));
  endtask

  initial begin
    int dones;
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.acc   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset rom_addr", 32'(bus.rom_addr), 32'd0);
    check("reset act", 32'(bus.act), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("zero",  26'sd0,       11'h400, ACT_ZERO);
    do_op("mid",   26'sd47628,   11'h574, ACT_372);
    do_op("ovf",   26'sd200000,  11'h7FF, ACT_OVF);
    do_op("unf",  -26'sd200000,  11'h000, ACT_UNF);

    // Negative floor, with start re-pulsed during READ
    @(negedge clk);
    bus.acc   = -26'sd75600;
    bus.start = 1'b1;
    @(posedge clk);  // E0
    #1;
    bus.start = 1'b0;
    @(posedge clk);  // E1 -> READ
    #1;
    check("neg rom_addr", 32'(bus.rom_addr), 32'h1B1);
    bus.acc   = 26'sd200000;
    bus.start = 1'b1;
    @(posedge clk);  // E2, start ignored
    #1;
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dones++;
      if (i == 0) check("neg act", 32'(bus.act), 32'(ACT_NEG));
    end
    check("neg single_done", dones, 32'd1);
    check("neg idle_after", 32'(bus.busy), 32'd0);
    check("neg act_kept", 32'(bus.act), 32'(ACT_NEG));

    // Reset in the middle of an operation
    @(negedge clk);
    bus.acc   = 26'sd47628;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);  // now in READ
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst act", 32'(bus.act), 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst done", 32'(bus.done), 32'd0);
    check("midrst rom_addr", 32'(bus.rom_addr), 32'd0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dones++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dones++;
    end
    check("midrst no_done", dones, 32'd0);
    check("midrst busy_idle", 32'(bus.busy), 32'd0);

    do_op("after_rst", 26'sd47628, 11'h574, ACT_372);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
